z80_debug_uart: RTL and testbench
=================================

// Module: z80_debug_uart
// PURPOSE
//  Consumer of Z80 (tv80s) I/O writes to the debug port. Each OUT to PORT_ADDR is captured once,
//  queued in a FIFO and serialised as 8N1 on a TX line, so firmware printf/debug bytes reach a host.
//  Sits on the Z80 I/O bus beside the MMU. Drives no memory; its optional status read drives the
//  Z80 data-in mux.
// PARAMETERS
//  PORT_ADDR      8'h01  I/O port, compared against addr[7:0]; OUT here = data byte
//  CLKS_PER_BIT   16     clk cycles per UART bit, >=2
//  FIFO_AW        4      FIFO depth = 2**FIFO_AW entries
// PORTS
//  clk         in   1  system / Z80 clock
//  reset_n     in   1  async active-low reset
//  addr        in   8  Z80 A[7:0]
//  wr_data     in   8  Z80 dout
//  iorq_n      in   1  Z80 IORQ_n
//  wr_n        in   1  Z80 WR_n
//  rd_n        in   1  Z80 RD_n
//  rd_data     out  8  status byte to Z80 di mux (STATUS_RD_EN only, else 0)
//  rd_oe       out  1  rd_data valid this cycle (else 0)
//  tx          out  1  serial out, idle high
//  tx_busy     out  1  frame in progress or FIFO non-empty
//  overflow    out  1  sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: tx=1, tx_busy=0, overflow=0, rd_oe=0, rd_data=0, FIFO empty, FSM IDLE. Async assert,
//   sync deassert. Reset mid-frame aborts the frame; tx returns high at once; queued bytes are lost.
//  Write capture: wr_hit = !iorq_n & !wr_n & addr==PORT_ADDR. Registered wr_hit_q.
//   push = wr_hit & !wr_hit_q: exactly one push per OUT, however many cycles the strobe is held.
//   wr_data is sampled in the push cycle.
//  FIFO: wr/rd pointers FIFO_AW+1 bits; empty = ptrs equal; full = MSB differs, rest equal.
//   A push is accepted when !full, or when full with a pop in the same cycle.
//   A push refused when full sets overflow (sticky) and leaves FIFO contents unchanged.
//   Simultaneous push and pop when empty: the pop does not occur; the byte is queued.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE/START.
//   IDLE: if !empty, pop into shift reg, go START. tx=1.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits LSB first, CLKS_PER_BIT each; 3-bit bit counter.
//   STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if !empty, pop and go directly to START
//    (back-to-back, no idle gap); else go IDLE.
//   Baud counter reloads at every state change; the bit counter wraps 7->0 on the DATA exit.
//  Latency: push at edge N into an empty FIFO, IDLE -> pop at N+1, tx falls after edge N+2.
//   Frame = 10*CLKS_PER_BIT cycles.
//  tx_busy = (state!=IDLE) | !empty.
// CONFIGURATION
//  `define Z80_DEBUG_UART_STATUS_RD_EN
//   Present: IN from PORT_ADDR+1 (!iorq_n & !rd_n) sets rd_oe=1 combinationally.
//    rd_data={tx_busy,overflow,full,empty,level[3:0]}; level saturates at 15.
//    overflow clears on the falling edge of that read strobe, unless a drop occurs the same cycle
//    (the set wins).
//   Absent: rd_oe=0, rd_data=8'h00. overflow is cleared only by reset.
// STRUCTURE
//  Shared include z80_debug_defs.vh: FSM state encodings (IDLE/START/DATA/STOP),
//   status bit positions, default PORT_ADDR.
//  Sub-module sync_fifo (params DW=8, AW=FIFO_AW): push/pop/full/empty/level.
//  Top level holds the strobe edge detect, TX FSM, baud and bit counters, and the status mux.
// TESTING (CLKS_PER_BIT=4, FIFO_AW=2)
//  1 Reset: hold reset_n=0 -> tx=1, tx_busy=0, overflow=0. Release -> no change while the bus
//    is idle.
//  2 OUT (01),8'hA5 with strobe held 3 cycles -> exactly one frame on tx: 0,1,0,1,0,0,1,0,1,1
//    (4 clk each); tx falls 2 cycles after the strobe edge.
//  3 Five OUTs 8'h10..8'h14 back-to-back during frame 1 -> 8'h10..8'h13 sent with no idle gap
//    between frames; 8'h14 dropped; overflow=1.
//  4 OUT to port 8'h02, and IN from 8'h01 -> no push, tx stays 1, tx_busy=0.
//  5 Reset asserted mid-DATA of 8'hFF with 2 bytes queued -> tx=1 immediately; after release
//    no further frames.
//  6 STATUS_RD_EN: after test 3, IN (02) returns {1,1,x,0,level}; overflow=0 after the strobe
//    ends. Without the macro: rd_oe=0 throughout.

Source files
------------

// File: rtl/z80_debug_uart_pkg.sv
// Shared types for the Z80 debug UART: TX FSM states,
// status-byte bit positions, default port and level helper.
package z80_debug_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] DEFAULT_PORT_ADDR = 8'h01;

  localparam int STS_EMPTY = 4;
  localparam int STS_FULL  = 5;
  localparam int STS_OVF   = 6;
  localparam int STS_BUSY  = 7;

  // 4-bit status level field, saturating at 15
  function automatic logic [3:0] sat_level(
    input logic [31:0] lvl
  );
    return (lvl > 32'd15) ? 4'hf : lvl[3:0];
  endfunction

endpackage

// File: rtl/z80_debug_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO, pointers one bit wider than the address.
// Ports: push/din in, pop/dout out (show-ahead), full, empty, level.
module sync_fifo
  import z80_debug_uart_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // a full FIFO still takes a byte when one leaves this cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/z80_debug_uart.sv
// Z80 debug UART: OUT to PORT_ADDR queues a byte, sent as 8N1 on tx.
// Ports: Z80 bus in, tx/tx_busy/overflow out, rd_data/rd_oe status read.
// Macro Z80_DEBUG_UART_STATUS_RD_EN enables the IN (PORT_ADDR+1) status.
module z80_debug_uart
  import z80_debug_uart_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR    = DEFAULT_PORT_ADDR,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  output logic [7:0] rd_data,
  output logic       rd_oe,
  output logic       tx,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t      state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           wr_hit;
  logic           wr_hit_q;
  logic           push;
  logic           pop;
  logic           drop;
  logic           last_tick;
  logic [7:0]     fifo_dout;
  logic           full;
  logic           empty;
  logic [FIFO_AW:0] fifo_level;

  // one push per OUT, however long the strobe is held
  assign wr_hit = ~iorq_n & ~wr_n & (addr == PORT_ADDR);
  assign push   = wr_hit & ~wr_hit_q;

  assign last_tick = (baud_cnt == BAUD_LAST);
  assign pop = ~empty &
               ((state == ST_IDLE) |
                ((state == ST_STOP) & last_tick));
  assign drop = push & full & ~pop;

  assign tx_busy = (state != ST_IDLE) | ~empty;

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (wr_data),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_hit_q <= 1'b0;
    else          wr_hit_q <= wr_hit;
  end

  // tx is registered from the state one cycle behind, uniformly,
  // so every bit keeps exactly CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= (state == ST_START) ? 1'b0 :
            (state == ST_DATA)  ? shreg[0] : 1'b1;
      unique case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            shreg <= fifo_dout;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (last_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (last_tick) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (last_tick) begin
            baud_cnt <= '0;
            if (!empty) begin
              shreg <= fifo_dout;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef Z80_DEBUG_UART_STATUS_RD_EN
  logic rd_hit;
  logic rd_hit_q;

  assign rd_hit = ~iorq_n & ~rd_n & (addr == PORT_ADDR + 8'd1);
  assign rd_oe  = rd_hit;

  always_comb begin
    rd_data = 8'h00;
    if (rd_hit) begin
      rd_data[STS_BUSY]  = tx_busy;
      rd_data[STS_OVF]   = overflow;
      rd_data[STS_FULL]  = full;
      rd_data[STS_EMPTY] = empty;
      rd_data[3:0]       = sat_level(32'(fifo_level));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_hit_q <= 1'b0;
    else          rd_hit_q <= rd_hit;
  end

  // a drop in the same cycle as the read release keeps the flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overflow <= 1'b0;
    else if (drop)               overflow <= 1'b1;
    else if (rd_hit_q & ~rd_hit) overflow <= 1'b0;
  end
`else
  logic unused_sts;

  assign unused_sts = ^{rd_n, fifo_level};
  assign rd_oe      = 1'b0;
  assign rd_data    = 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_z80_debug_uart.sv
// Self-checking bench for z80_debug_uart (CLKS_PER_BIT=4, FIFO_AW=2).
// A line monitor decodes tx frames; expectations come from a byte queue model.
module tb_z80_debug_uart;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

`ifdef Z80_DEBUG_UART_STATUS_RD_EN
  localparam bit STS = 1'b1;
`else
  localparam bit STS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       iorq_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic [7:0] rd_data;
  logic       rd_oe;
  logic       tx;
  logic       tx_busy;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic       mon_busy = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];

  z80_debug_uart #(
    .PORT_ADDR    (8'h01),
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wr_data  (wr_data),
    .iorq_n   (iorq_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .rd_data  (rd_data),
    .rd_oe    (rd_oe),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // UART line monitor: frame starts on first low cycle, each bit
  // must stay constant for CPB cycles
  initial begin : mon
    int c;
    int st;
    logic [7:0] sh;
    logic bv;
    c = 0; st = 0; sh = '0; bv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (tx === 1'b0) begin
          mon_busy = 1'b1;
          c = 0;
          st = cyc;
          bv = 1'b0;
        end
      end else begin
        c++;
        if (c % CPB == 0) begin
          bv = tx;
          if (c / CPB >= 1 && c / CPB <= 8) sh[c / CPB - 1] = tx;
        end else begin
          chk("bit_stable", {31'd0, tx}, {31'd0, bv});
        end
        if (c == FRAME - 1) begin
          chk("stop_bit", {31'd0, bv}, 32'd1);
          rx_q.push_back(sh);
          rx_t.push_back(st);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic bus_idle();
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
  endtask

  task automatic out_port(input logic [7:0] a, input logic [7:0] d,
                          input int hold);
    @(negedge clk);
    addr = a; wr_data = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    bus_idle();
  endtask

  task automatic wait_idle(input int max);
    int i;
    bit ok;
    ok = 1'b0;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (!tx_busy && !mon_busy && tx === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag, input bit b2b);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    if (b2b)
      for (int i = 1; i < n; i++)
        chk({tag, "_gap"}, rx_t[i] - rx_t[i-1], FRAME);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    int n;
    int acc;
    bit low_seen;
    logic [7:0] b;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_rd_oe", {31'd0, rd_oe}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("post_rst_ovf", {31'd0, overflow}, 32'd0);

    // 2: one OUT, strobe held 3 cycles, exact latency
    @(negedge clk);
    c0 = cyc;
    addr = 8'h01; wr_data = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    chk("lat_tx_k1", {31'd0, tx}, 32'd1);
    chk("lat_busy_k1", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    chk("lat_tx_k2", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("lat_tx_k3", {31'd0, tx}, 32'd0);
    bus_idle();
    wait_idle(200);
    if (rx_t.size() > 0) chk("lat_start", rx_t[0], c0 + 3);
    exp_q.push_back(8'hA5);
    compare_rx("single", 1'b0);

    // 3: overfill during a frame
    out_port(8'h01, 8'h3C, 1);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      out_port(8'h01, b, 1);
      if (i < DEPTH) exp_q.push_back(b);
    end
    @(negedge clk);
    chk("ovf_set", {31'd0, overflow}, 32'd1);

    // 6: status read while the FIFO is full
    addr = 8'h02; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk("sts_rd_oe", {31'd0, rd_oe}, {31'd0, STS});
    chk("sts_rd_data", {24'd0, rd_data}, STS ? 32'hE4 : 32'h00);
    @(negedge clk);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    #1;
    chk("sts_ovf_after", {31'd0, overflow}, STS ? 32'd0 : 32'd1);
    chk("sts_rd_oe_off", {31'd0, rd_oe}, 32'd0);
    wait_idle(400);
    compare_rx("b2b", 1'b1);

    // 4: wrong port write and IN from the data port
    out_port(8'h02, 8'h55, 2);
    @(negedge clk);
    addr = 8'h01; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk("in01_rd_oe", {31'd0, rd_oe}, 32'd0);
    @(negedge clk);
    bus_idle();
    low_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("nohit_tx", {31'd0, low_seen}, 32'd0);
    chk("nohit_busy", {31'd0, tx_busy}, 32'd0);
    chk("nohit_rx", rx_q.size(), 0);

    // 5: reset mid-DATA with two bytes queued
    out_port(8'h01, 8'hFF, 1);
    out_port(8'h01, 8'h11, 1);
    out_port(8'h01, 8'h22, 1);
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("midrst_quiet", {31'd0, low_seen}, 32'd0);
    chk("midrst_rx", rx_q.size(), 0);

    // random bursts: first byte is popped at once, then DEPTH more fit
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 7);
      acc = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        out_port(8'h01, b, $urandom_range(1, 2));
        if (i == 0 || i - 1 < DEPTH) begin
          exp_q.push_back(b);
          acc++;
        end
      end
      @(negedge clk);
      chk("rnd_ovf", {31'd0, overflow}, (n - 1 > DEPTH) ? 32'd1 : 32'd0);
      wait_idle(600);
      compare_rx("rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
